// File: rtl/frame_sequencer.sv
// frame_sequencer
// ---------------
// Frame-level controller in front of image_processor. A start command makes
// it emit one row of pad pixels, pass exactly one frame of source pixels
// straight through, then emit one more pad row. This way the 3x3 window also
// produces output for the first and last image rows. It then waits until the
// processor has delivered every filtered result and pulses o_done for one
// cycle.
//
// Handshakes: a beat transfers on a rising edge where valid && ready are both
// high. The source side (i_s_data_valid / o_s_data_ready) only moves in BODY.
// The downstream side (o_m_data_valid / i_m_data_ready) holds valid and data
// stable while ready is low. In BODY the two sides are wired together
// combinationally, so the pass-through adds no latency.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_abort    frame start / abandon current frame
//   i_s_data_valid,
//   i_s_data,
//   o_s_data_ready      DMA source pixel stream
//   o_m_data_valid,
//   o_m_data,
//   i_m_data_ready      pixel stream toward image_processor
//   i_result_valid      one filtered result left the processor
//   o_busy              high in every state except IDLE
//   o_done              one-cycle pulse when the frame has drained
//   o_start_err         one-cycle pulse for a start received while busy
//   o_dbg_state         current FSM state encoding (debug)

module frame_sequencer #(
    parameter int          IMG_WIDTH  = 512,
    parameter int          IMG_HEIGHT = 512,
    parameter logic [7:0]  PAD_VALUE  = 8'h00,
    parameter int          OUT_COUNT  = 261120
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_abort,
    input  logic       i_s_data_valid,
    input  logic [7:0] i_s_data,
    output logic       o_s_data_ready,
    output logic       o_m_data_valid,
    output logic [7:0] o_m_data,
    input  logic       i_m_data_ready,
    input  logic       i_result_valid,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_start_err,
    output logic [2:0] o_dbg_state
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam int RES_W = $clog2(OUT_COUNT + 1);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [RES_W-1:0] RES_MAX  = RES_W'(OUT_COUNT);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PAD_TOP = 3'd1,
        ST_BODY    = 3'd2,
        ST_PAD_BOT = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t           state, state_next;
    logic [COL_W-1:0] col, col_next;
    logic [ROW_W-1:0] row, row_next;
    logic [RES_W-1:0] res, res_next, res_counted;
    logic             start_err;
    logic             beat;

    // Datapath muxing. Outputs are combinational from state so that BODY
    // is a zero-latency pass-through.
    always_comb begin
        o_m_data_valid = 1'b0;
        o_m_data       = 8'h00;
        o_s_data_ready = 1'b0;
        case (state)
            ST_PAD_TOP, ST_PAD_BOT: begin
                o_m_data_valid = 1'b1;
                o_m_data       = PAD_VALUE;
            end
            ST_BODY: begin
                o_m_data_valid = i_s_data_valid;
                o_m_data       = i_s_data;
                o_s_data_ready = i_m_data_ready;
            end
            default: ;
        endcase
    end

    assign beat = o_m_data_valid && i_m_data_ready;

    // Result count including this cycle's pulse. It saturates at the
    // terminal value, so extra pulses after the frame has fully drained
    // cannot move it past OUT_COUNT.
    always_comb begin
        res_counted = res;
        if (state != ST_IDLE && i_result_valid && res != RES_MAX)
            res_counted = res + 1'b1;
    end

    always_comb begin
        state_next = state;
        col_next   = col;
        row_next   = row;
        res_next   = res_counted;
        case (state)
            ST_IDLE: begin
                res_next = '0;
                // A simultaneous abort cancels the start.
                if (i_start && !i_abort) begin
                    state_next = ST_PAD_TOP;
                    col_next   = '0;
                    row_next   = '0;
                end
            end
            ST_PAD_TOP: begin
                if (beat) begin
                    if (col == COL_LAST) begin
                        col_next   = '0;
                        state_next = ST_BODY;
                    end else begin
                        col_next = col + 1'b1;
                    end
                end
            end
            ST_BODY: begin
                if (beat) begin
                    if (col == COL_LAST) begin
                        col_next = '0;
                        if (row == ROW_LAST) begin
                            row_next   = '0;
                            state_next = ST_PAD_BOT;
                        end else begin
                            row_next = row + 1'b1;
                        end
                    end else begin
                        col_next = col + 1'b1;
                    end
                end
            end
            ST_PAD_BOT: begin
                if (beat) begin
                    if (col == COL_LAST) begin
                        col_next   = '0;
                        state_next = ST_DRAIN;
                    end else begin
                        col_next = col + 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                // Results may all have arrived during BODY/PAD_BOT. In that
                // case DRAIN lasts a single cycle.
                if (res_counted == RES_MAX)
                    state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
                col_next   = '0;
                row_next   = '0;
                res_next   = '0;
            end
            default: begin
                state_next = ST_IDLE;
                col_next   = '0;
                row_next   = '0;
                res_next   = '0;
            end
        endcase

        // Abort overrides every other transition.
        if (state != ST_IDLE && i_abort) begin
            state_next = ST_IDLE;
            col_next   = '0;
            row_next   = '0;
            res_next   = '0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= ST_IDLE;
            col       <= '0;
            row       <= '0;
            res       <= '0;
            start_err <= 1'b0;
        end else begin
            state     <= state_next;
            col       <= col_next;
            row       <= row_next;
            res       <= res_next;
            start_err <= i_start && (state != ST_IDLE);
        end
    end

    assign o_busy      = (state != ST_IDLE);
    assign o_done      = (state == ST_DONE);
    assign o_start_err = start_err;
    assign o_dbg_state = state;

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-level controller placed in front of `image_processor`. It accepts a start command and injects one row of pad pixels before the frame, so the 3x3 window produces output for the first and last image rows. It then passes exactly one frame of DMA input pixels and injects one row of pad pixels after the frame. It counts filtered results from the convolution output stream and raises a one-cycle done pulse when the whole frame has drained.

## Interface
Parameters:
- `IMG_WIDTH`, 512, pixels per line.
- `IMG_HEIGHT`, 512, lines per frame.
- `PAD_VALUE`, 8'h00, pixel value injected in pad rows.
- `OUT_COUNT`, 261120 (510*512), filtered results expected per frame.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  start one frame; honoured only in IDLE.
- `i_abort`  in  1  abandon the current frame.
- `i_s_data_valid`  in  1  DMA input pixel valid.
- `i_s_data`  in  8  DMA input pixel.
- `o_s_data_ready`  out  1  input pixel accepted when high together with valid.
- `o_m_data_valid`  out  1  pixel valid toward `image_processor` `i_data_valid`.
- `o_m_data`  out  8  pixel toward `image_processor` `i_data`.
- `i_m_data_ready`  in  1  from `image_processor` `o_data_ready`.
- `i_result_valid`  in  1  one filtered result left the processor (output handshake fired).
- `o_busy`  out  1  high in every state except IDLE.
- `o_done`  out  1  one-cycle pulse at frame completion.
- `o_start_err`  out  1  one-cycle pulse when `i_start` arrives while not IDLE.

## Operation
- States: IDLE, PAD_TOP, BODY, PAD_BOT, DRAIN, DONE.
- A downstream beat transfers when `o_m_data_valid && i_m_data_ready`. A source beat transfers when `i_s_data_valid && o_s_data_ready`.
- IDLE: `o_m_data_valid`=0 and `o_s_data_ready`=0. On `i_start`, clear all counters and go to PAD_TOP.
- PAD_TOP: `o_m_data_valid`=1, `o_m_data`=PAD_VALUE, `o_s_data_ready`=0.
  - Column counter increments on each downstream beat.
  - After IMG_WIDTH beats, go to BODY.
- BODY: combinational pass-through.
  - `o_m_data_valid`=`i_s_data_valid`, `o_m_data`=`i_s_data`, `o_s_data_ready`=`i_m_data_ready`.
  - Column counter wraps at IMG_WIDTH-1 and the row counter then increments.
  - On the beat with column=IMG_WIDTH-1 and row=IMG_HEIGHT-1, go to PAD_BOT.
- PAD_BOT: same behaviour as PAD_TOP. After IMG_WIDTH beats, go to DRAIN.
- DRAIN: no valid toward the processor; `o_s_data_ready`=0. Wait for the result count.
- DONE: `o_done`=1 for exactly one cycle, then go to IDLE.
- Result counter:
  - Increments on `i_result_valid` in any non-IDLE state and saturates at OUT_COUNT.
  - `i_result_valid` in IDLE is ignored.
  - DRAIN goes to DONE in the cycle the count equals OUT_COUNT, including the increment made in that cycle.
  - If the count reaches OUT_COUNT before DRAIN, DRAIN exits to DONE on its first cycle.
- Counter widths: column `$clog2(IMG_WIDTH)`, row `$clog2(IMG_HEIGHT)`, result `$clog2(OUT_COUNT+1)`. No counter may wrap beyond its terminal value.
- `i_abort` in any non-IDLE state: go to IDLE next cycle, with no `o_done` pulse and counters cleared. `i_abort` has priority over every other transition.
- `i_start` in a non-IDLE state: ignored, and `o_start_err` pulses the next cycle. `i_start` and `i_abort` together in IDLE: stay IDLE.

## Timing
- Reset values: state=IDLE; `o_busy`, `o_done`, `o_start_err`, `o_m_data_valid`, `o_s_data_ready` all 0; `o_m_data`=0; all counters 0.
- `i_rst` mid-frame behaves exactly like abort. It takes effect at the next edge and has priority over `i_abort`.
- Start latency: `i_start` sampled high at edge N makes `o_busy` and pad `o_m_data_valid` high after edge N.
- Pad states: valid stays high and data stays stable while `i_m_data_ready`=0; no beat is counted during the stall.
- BODY adds zero latency: the path from `i_s_data_valid`/`i_m_data_ready` to the outputs is combinational.
- State changes (PAD_TOP→BODY, BODY→PAD_BOT, PAD_BOT→DRAIN) happen at the edge that accepts the terminal beat, so no idle cycle is inserted.
- Done timing: the edge at which the result count reaches OUT_COUNT in DRAIN enters DONE. `o_done` is high in the following cycle only. IDLE follows, with `o_busy`=0.

## Test plan
Run with IMG_WIDTH=4, IMG_HEIGHT=3, OUT_COUNT=6, PAD_VALUE=8'hAA unless stated.
- Nominal frame: ready always 1; start, then feed pixels 1..12 with no gaps, then 6 results. Required downstream sequence is AA×4, 1..12, AA×4 (20 beats in consecutive cycles). One `o_done` pulse follows the 6th result.
- Backpressure: toggle `i_m_data_ready` 1/0 every cycle and insert random source valid gaps. Required sequence is the same 20 beats with no duplicates or drops, and pad data stays held while stalled.
- Early results: drive all 6 `i_result_valid` during BODY. Required: DRAIN lasts one cycle, then DONE; the result count holds at 6 even with extra pulses.
- Abort mid-BODY after pixel 5: required IDLE next cycle, `o_busy`=0, no `o_done`. A new start then re-emits 4 pad beats first.
- Start while busy: `i_start` during PAD_BOT. Required: one-cycle `o_start_err`, and the frame completes normally with one `o_done`.
- Reset mid-DRAIN: assert `i_rst` for one cycle. Required: all outputs equal reset values after that edge, and `i_result_valid` pulses in IDLE do not advance the result count.
